// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// One op per start; WIDTH iterations, then a one-cycle result strobe carrying
// the destination tag captured with the operands. Both ops run on operand
// magnitudes (shift-add multiply, restoring divide) and apply the sign at the end.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH:0]     acc_reg;      // running partial product high half / remainder
    logic [WIDTH-1:0]   lo_reg;       // multiplier being consumed / dividend -> quotient
    logic [WIDTH-1:0]   opb_reg;      // |multiplicand| or |divisor|
    logic               neg_reg;      // result must be negated at completion
    logic               div0_reg;     // divisor was zero
    logic               ovf_reg;      // MIN / -1
    logic [TAG_W-1:0]   tag_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               exc_reg;
    logic [TAG_W-1:0]   tag_out_reg;

    logic               iterating;
    logic               last_iter;
    logic               capture;
    logic [WIDTH-1:0]   abs_a, abs_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_shift;
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH:0]     acc_next;
    logic [WIDTH-1:0]   lo_next;
    logic [2*WIDTH-1:0] prod_mag, prod_signed;
    logic [WIDTH:0]     prod_top;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   fin_result;
    logic               fin_exc;

    assign busy       = (state_reg == S_MULT) || (state_reg == S_DIV);
    assign result_rdy = (state_reg == S_DONE);
    assign result     = result_reg;
    assign exception  = exc_reg;
    assign tag_out    = tag_out_reg;

    assign iterating = busy && !flush;
    assign last_iter = (cnt_reg == LAST_CNT);
    // A start is accepted exactly when the FSM leaves IDLE/DONE for an op state.
    assign capture   = !busy && ((state_next == S_MULT) || (state_next == S_DIV));

    assign abs_a = operand_a[WIDTH-1] ? (~operand_a + 1'b1) : operand_a;
    assign abs_b = operand_b[WIDTH-1] ? (~operand_b + 1'b1) : operand_b;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: flush outranks starts and iteration; mult wins over div.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (flush)          state_next = S_IDLE;
                else if (ctrl_mult) state_next = S_MULT;
                else if (ctrl_div)  state_next = S_DIV;
                else                state_next = S_IDLE;
            end
            S_MULT, S_DIV: begin
                if (flush)          state_next = S_IDLE;
                else if (last_iter) state_next = S_DONE;
                else                state_next = state_reg;
            end
            default:                state_next = S_IDLE;
        endcase
    end

    // One iteration step: shift-add for multiply, restoring step for divide.
    always_comb begin
        mul_sum    = acc_reg + (lo_reg[0] ? {1'b0, opb_reg} : {(WIDTH+1){1'b0}});
        mul_shift  = {mul_sum, lo_reg} >> 1;
        div_rem_sh = {acc_reg[WIDTH-1:0], lo_reg[WIDTH-1]};
        div_diff   = div_rem_sh - {1'b0, opb_reg};
        acc_next   = acc_reg;
        lo_next    = lo_reg;
        if (state_reg == S_MULT) begin
            acc_next = mul_shift[2*WIDTH:WIDTH];
            lo_next  = mul_shift[WIDTH-1:0];
        end else if (state_reg == S_DIV) begin
            acc_next = div_diff[WIDTH] ? div_rem_sh : div_diff;
            lo_next  = {lo_reg[WIDTH-2:0], ~div_diff[WIDTH]};
        end
    end

    // Signed result of the op as it will stand after the final iteration.
    always_comb begin
        prod_mag    = {acc_next[WIDTH-1:0], lo_next};
        prod_signed = neg_reg ? (~prod_mag + 1'b1) : prod_mag;
        prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
        quo_signed  = neg_reg ? (~lo_next + 1'b1) : lo_next;
        fin_result  = '0;
        fin_exc     = 1'b0;
        if (state_reg == S_MULT) begin
            fin_result = prod_signed[WIDTH-1:0];
            // Overflow when the upper half is not a sign extension of bit WIDTH-1.
            fin_exc    = !((&prod_top) || !(|prod_top));
        end else if (div0_reg) begin
            fin_result = '0;
            fin_exc    = 1'b1;
        end else begin
            fin_result = quo_signed;
            fin_exc    = ovf_reg;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg     <= '0;
            acc_reg     <= '0;
            lo_reg      <= '0;
            opb_reg     <= '0;
            neg_reg     <= 1'b0;
            div0_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
            tag_reg     <= '0;
            result_reg  <= '0;
            exc_reg     <= 1'b0;
            tag_out_reg <= '0;
        end else begin
            if (capture) begin
                cnt_reg  <= '0;
                acc_reg  <= '0;
                lo_reg   <= abs_a;
                opb_reg  <= abs_b;
                neg_reg  <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                div0_reg <= (operand_b == '0);
                ovf_reg  <= (operand_a == MIN_VAL) && (operand_b == '1);
                tag_reg  <= tag_in;
            end else if (iterating) begin
                cnt_reg  <= cnt_reg + 1'b1;
                acc_reg  <= acc_next;
                lo_reg   <= lo_next;
            end
            if (iterating && last_iter) begin
                result_reg  <= fin_result;
                exc_reg     <= fin_exc;
                tag_out_reg <= tag_reg;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: a cycle-level arithmetic model checked on
// every cycle, plus hand-computed literals for each directed operation.
module tb_multdiv_unit;

    localparam int W = 32;
    localparam int T = 5;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clock = 1'b0;
    logic         reset;
    logic         ctrl_mult, ctrl_div, flush;
    logic [W-1:0] operand_a, operand_b;
    logic [T-1:0] tag_in;
    logic         busy, result_rdy, exception;
    logic [W-1:0] result;
    logic [T-1:0] tag_out;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_unit #(.WIDTH(W), .TAG_W(T)) dut (
        .clock(clock), .reset(reset), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .flush(flush), .operand_a(operand_a), .operand_b(operand_b), .tag_in(tag_in),
        .busy(busy), .result_rdy(result_rdy), .result(result), .exception(exception),
        .tag_out(tag_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic meaning of one operation on WIDTH-bit signed operands.
    function automatic void model_op(input logic is_mul, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] r, output logic e);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mul) begin
            p = sa * sb;
            r = p[W-1:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (sb == 0) begin
            r = '0;
            e = 1'b1;
        end else if (sa == -64'sd2147483648 && sb == -1) begin
            r = MINV;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[W-1:0];
            e = 1'b0;
        end
    endfunction

    // Model: an accepted op occupies W cycles, then its result appears for one cycle.
    int           m_left = 0;
    bit           m_valid = 0;
    logic         m_rdy, m_exc, p_exc;
    logic [W-1:0] m_res, p_res;
    logic [T-1:0] m_tag, p_tag;

    always @(posedge clock) begin
        if (reset) begin
            m_left = 0; m_rdy = 0; m_res = '0; m_exc = 0; m_tag = '0; m_valid = 1;
        end else if (m_left > 0) begin
            m_rdy = 0;
            if (flush) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_rdy = 1; m_res = p_res; m_exc = p_exc; m_tag = p_tag;
                end
            end
        end else begin
            m_rdy = 0;
            if (!flush && (ctrl_mult || ctrl_div)) begin
                m_left = W;
                p_tag  = tag_in;
                model_op(ctrl_mult, operand_a, operand_b, p_res, p_exc);
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clock) begin
        if (m_valid) begin
            check("cyc_busy", busy, m_left > 0);
            check("cyc_rdy", result_rdy, m_rdy);
            check("cyc_result", result, m_res);
            check("cyc_exc", exception, m_exc);
            check("cyc_tag", tag_out, m_tag);
        end
    end

    // Wait (bounded) for the strobe; edges = edges after the capture edge, 0 if never.
    task automatic wait_rdy(output int edges);
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (result_rdy === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    // Called just after a negedge; returns at the negedge inside the strobe cycle.
    task automatic run_op(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [T-1:0] t, input logic [W-1:0] exp_r, input logic exp_e,
                          input string name, output int edges);
        ctrl_mult = m; ctrl_div = d; operand_a = a; operand_b = b; tag_in = t;
        @(negedge clock);
        ctrl_mult = 0; ctrl_div = 0; operand_a = ~a; operand_b = ~b; tag_in = ~t;
        wait_rdy(edges);
        check({name, "_latency"}, edges, 32);
        check({name, "_result"}, result, exp_r);
        check({name, "_exc"}, exception, exp_e);
        check({name, "_tag"}, tag_out, t);
        $display("op %s a=%h b=%h tag=%0d -> result=%h exc=%0b tag_out=%0d edges=%0d",
                 name, a, b, t, result, exception, tag_out, edges);
    endtask

    initial begin
        int edges;
        int seen;
        reset = 1; ctrl_mult = 0; ctrl_div = 0; flush = 0;
        operand_a = '0; operand_b = '0; tag_in = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_rdy", result_rdy, 0);
        check("rst_result", result, 0);
        check("rst_exc", exception, 0);
        check("rst_tag", tag_out, 0);
        reset = 0;
        @(negedge clock);

        run_op(1, 0, 32'd7, -32'sd6, 5'd5, 32'hFFFF_FFD6, 0, "mul_7_m6", edges);
        @(negedge clock);
        run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 5'd6, 32'h0, 1, "mul_2p16_sq", edges);
        @(negedge clock);
        // -1 * MIN = +2^31, which is not representable in 32-bit signed: flagged.
        run_op(1, 0, 32'hFFFF_FFFF, MINV, 5'd7, MINV, 1, "mul_m1_min", edges);
        @(negedge clock);
        run_op(0, 1, 32'd100, -32'sd7, 5'd8, 32'hFFFF_FFF2, 0, "div_100_m7", edges);
        @(negedge clock);
        run_op(0, 1, -32'sd100, 32'd7, 5'd9, 32'hFFFF_FFF2, 0, "div_m100_7", edges);
        @(negedge clock);
        run_op(0, 1, 32'd5, 32'd0, 5'd10, 32'h0, 1, "div_5_0", edges);
        @(negedge clock);
        run_op(0, 1, -32'sd7, 32'd2, 5'd11, 32'hFFFF_FFFD, 0, "div_m7_2", edges);
        @(negedge clock);
        run_op(0, 1, MINV, 32'hFFFF_FFFF, 5'd12, MINV, 1, "div_min_m1", edges);
        // Back-to-back start issued in the strobe cycle.
        run_op(1, 0, 32'd3, 32'd4, 5'd9, 32'd12, 0, "mul_b2b", edges);
        check("b2b_strobe_gap", edges + 1, 33);

        // Flush in the strobe cycle together with a start: start ignored.
        flush = 1; ctrl_div = 1; operand_a = 32'd40; operand_b = 32'd2; tag_in = 5'd1;
        @(negedge clock);
        flush = 0; ctrl_div = 0;
        check("flush_done_busy", busy, 0);
        $display("op flush_in_done -> busy=%0b rdy=%0b", busy, result_rdy);

        // Flush mid-multiply: no strobe, previous result and tag hold.
        @(negedge clock);
        ctrl_mult = 1; operand_a = 32'd9; operand_b = 32'd9; tag_in = 5'd3;
        @(negedge clock);
        ctrl_mult = 0;
        repeat (9) @(negedge clock);
        flush = 1;
        @(negedge clock);
        flush = 0;
        check("flush_busy", busy, 0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (result_rdy !== 1'b0) seen++;
        end
        check("flush_no_strobe", seen, 0);
        check("flush_result_hold", result, 32'd12);
        check("flush_tag_hold", tag_out, 5'd9);
        $display("op flush_mid_mult -> strobes=%0d result=%h tag_out=%0d", seen, result, tag_out);

        // Reset in the middle of a divide clears everything.
        ctrl_div = 1; operand_a = 32'd1000; operand_b = 32'd3; tag_in = 5'd7;
        @(negedge clock);
        ctrl_div = 0;
        repeat (14) @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        check("midrst_busy", busy, 0);
        check("midrst_rdy", result_rdy, 0);
        check("midrst_result", result, 0);
        check("midrst_exc", exception, 0);
        check("midrst_tag", tag_out, 0);
        $display("op reset_mid_div -> busy=%0b result=%h tag_out=%0d", busy, result, tag_out);
        @(negedge clock);

        // Both starts high: multiply wins.
        run_op(1, 1, 32'd6, 32'd3, 5'd4, 32'd18, 0, "mul_and_div", edges);
        @(negedge clock);

        // A start while busy is ignored and not queued.
        ctrl_mult = 1; operand_a = 32'd2; operand_b = 32'd3; tag_in = 5'd1;
        @(negedge clock);
        ctrl_mult = 0;
        repeat (5) @(negedge clock);
        ctrl_div = 1; operand_a = 32'd50; operand_b = 32'd5; tag_in = 5'd2;
        @(negedge clock);
        ctrl_div = 0;
        wait_rdy(edges);
        check("busy_start_latency", edges, 26);
        check("busy_start_result", result, 32'd6);
        check("busy_start_tag", tag_out, 5'd1);
        $display("op start_while_busy -> result=%h tag_out=%0d edges=%0d", result, tag_out, edges);
        @(negedge clock);
        check("busy_start_not_queued", busy, 0);
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
